txt_palette: RTL and testbench

Pipelined text-mode colour stage for the VGA text path: turns per-pixel foreground/background palette indices and a glyph-on bit into a registered RGB word. Replaces the fixed bit-expansion colour map with two CPU-writable palettes, keeping that expansion as the reset contents. Adds blanking and an optional attribute-driven blink. Sits between the glyph/attribute fetch pipeline and the DAC pins, driven by the pixel clock.

---
 rtl/txt_pkg.sv | 30 +++
 rtl/txt_pal_ram.sv | 47 ++++
 rtl/txt_palette.sv | 151 +++++++++++++++
 tb/tb_txt_palette.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/txt_pkg.sv
// Shared definitions for the text-mode colour stage.
//   - COL_W=8 colour field positions: R[7:5], G[4:2], B[1:0]
//   - pal_sel_e : palette select encoding (PAL_BAK=0, PAL_FOR=1)
//   - default_col(idx) : reset expansion of a 4-bit index to an 8-bit colour
package txt_pkg;

   localparam int unsigned R_MSB = 7;
   localparam int unsigned R_LSB = 5;
   localparam int unsigned G_MSB = 4;
   localparam int unsigned G_LSB = 2;
   localparam int unsigned B_MSB = 1;
   localparam int unsigned B_LSB = 0;

   typedef enum logic {
      PAL_BAK = 1'b0,
      PAL_FOR = 1'b1
   } pal_sel_e;

   // Bit-expansion colour map: index bit 3 acts as the intensity bit and is
   // replicated into the top of every colour field.
   function automatic logic [7:0] default_col(input logic [3:0] idx);
      logic [7:0] c;
      c = '0;
      c[R_MSB:R_LSB] = {idx[3], idx[2], idx[2]};
      c[G_MSB:G_LSB] = {idx[3], idx[1], idx[1]};
      c[B_MSB:B_LSB] = {idx[3], idx[0]};
      return c;
   endfunction

endpackage

// File: rtl/txt_pal_ram.sv
// One CPU-writable colour palette.
//   clk_i, rst_i : pixel clock, synchronous active-high reset (restores defaults)
//   we_i         : write strobe; waddr_i / wdata_i give entry and colour
//   raddr_i      : read index; rdata_o is the registered read result
// A read of the entry being written in the same cycle returns the old value.
module txt_pal_ram
   import txt_pkg::*;
#(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned COL_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [COL_W-1:0] wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [COL_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** IDX_W;

   // The bit-expansion map only exists for the 4-bit/8-bit geometry; any other
   // geometry resets to the index itself, zero-extended or truncated.
   function automatic logic [COL_W-1:0] reset_col(input int unsigned i);
      logic [3:0] i4;
      i4 = i[3:0];
      if (IDX_W == 4 && COL_W == 8) return COL_W'(default_col(i4));
      else                          return COL_W'(i);
   endfunction

   logic [COL_W-1:0] mem_q [DEPTH];
   logic [COL_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= reset_col(i);
         rdata_q <= '0;
      end else begin
         if (we_i) mem_q[waddr_i] <= wdata_i;
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/txt_palette.sv
// Pipelined text-mode colour stage: palette indices + glyph bit -> RGB word.
// Optional feature macro: TXT_PALETTE_BLINK_EN (attribute-driven blink).
//   clk, rst       : pixel clock, synchronous active-high reset
//   pix_valid      : qualifies for_en/col_for/col_bak/blank/blink_attr
//   for_en         : glyph pixel lit (foreground palette)
//   col_for/col_bak: foreground / background palette indices
//   blank          : outside active area, forces black
//   blink_attr     : character blinks (macro builds only)
//   frame_tick     : one pulse per frame (macro builds only)
//   pal_we/pal_sel/pal_addr/pal_data : palette write port
//   rgb, rgb_valid : registered colour and its qualifier, 2 cycles latency
module txt_palette
   import txt_pkg::*;
#(
   parameter int unsigned IDX_W        = 4,
   parameter int unsigned COL_W        = 8,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_valid,
   input  logic             for_en,
   input  logic [IDX_W-1:0] col_for,
   input  logic [IDX_W-1:0] col_bak,
   input  logic             blank,
   input  logic             blink_attr,
   input  logic             frame_tick,
   input  logic             pal_we,
   input  logic             pal_sel,
   input  logic [IDX_W-1:0] pal_addr,
   input  logic [COL_W-1:0] pal_data,
   output logic [COL_W-1:0] rgb,
   output logic             rgb_valid
);

   logic [COL_W-1:0] for_rd;
   logic [COL_W-1:0] bak_rd;
   logic             we_for;
   logic             we_bak;

   assign we_for = pal_we && (pal_sel_e'(pal_sel) == PAL_FOR);
   assign we_bak = pal_we && (pal_sel_e'(pal_sel) == PAL_BAK);

   // Stage 1: palette reads are registered inside the RAMs.
   txt_pal_ram #(.IDX_W(IDX_W), .COL_W(COL_W)) u_for_pal (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (we_for),
      .waddr_i (pal_addr),
      .wdata_i (pal_data),
      .raddr_i (col_for),
      .rdata_o (for_rd)
   );

   txt_pal_ram #(.IDX_W(IDX_W), .COL_W(COL_W)) u_bak_pal (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (we_bak),
      .waddr_i (pal_addr),
      .wdata_i (pal_data),
      .raddr_i (col_bak),
      .rdata_o (bak_rd)
   );

   logic supp_d;

`ifdef TXT_PALETTE_BLINK_EN
   localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CNT_W-1:0] blink_cnt_q;
   logic [CNT_W-1:0] blink_cnt_d;
   logic             blink_phase_q;
   logic             blink_phase_d;

   // Counts every frame_tick regardless of pix_valid.
   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_tick) begin
         if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   // Suppression is resolved at acceptance, with the phase in force then.
   assign supp_d = blink_attr & blink_phase_q;
`else
   logic unused_blink;
   assign unused_blink = ^{blink_attr, frame_tick, (BLINK_FRAMES != 0)};
   assign supp_d       = 1'b0;
`endif

   // Stage 1 side-band registers, aligned with the RAM read data.
   logic s1_valid_q;
   logic s1_for_en_q;
   logic s1_blank_q;
   logic s1_supp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_for_en_q <= 1'b0;
         s1_blank_q  <= 1'b0;
         s1_supp_q   <= 1'b0;
      end else begin
         s1_valid_q  <= pix_valid;
         s1_for_en_q <= for_en;
         s1_blank_q  <= blank;
         s1_supp_q   <= supp_d;
      end
   end

   // Stage 2: colour mux, registered to the pins.
   logic [COL_W-1:0] rgb_q;
   logic [COL_W-1:0] rgb_d;
   logic             rgb_valid_q;

   always_comb begin
      rgb_d = bak_rd;
      if (s1_blank_q)                     rgb_d = '0;
      else if (s1_for_en_q && !s1_supp_q) rgb_d = for_rd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q       <= '0;
         rgb_valid_q <= 1'b0;
      end else begin
         rgb_q       <= rgb_d;
         rgb_valid_q <= s1_valid_q;
      end
   end

   assign rgb       = rgb_q;
   assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_txt_palette.sv
module tb_txt_palette;

   localparam int unsigned BF = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       pix_valid;
   logic       for_en;
   logic [3:0] col_for;
   logic [3:0] col_bak;
   logic       blank;
   logic       blink_attr;
   logic       frame_tick;
   logic       pal_we;
   logic       pal_sel;
   logic [3:0] pal_addr;
   logic [7:0] pal_data;
   logic [7:0] rgb;
   logic       rgb_valid;

   int checks = 0;
   int errors = 0;

   txt_palette #(.IDX_W(4), .COL_W(8), .BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_valid  (pix_valid),
      .for_en     (for_en),
      .col_for    (col_for),
      .col_bak    (col_bak),
      .blank      (blank),
      .blink_attr (blink_attr),
      .frame_tick (frame_tick),
      .pal_we     (pal_we),
      .pal_sel    (pal_sel),
      .pal_addr   (pal_addr),
      .pal_data   (pal_data),
      .rgb        (rgb),
      .rgb_valid  (rgb_valid)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   function automatic logic [7:0] dflt(input logic [3:0] i);
      return {i[3], i[2], i[2], i[3], i[1], i[1], i[3], i[0]};
   endfunction

   logic [7:0] bak_m [16];
   logic [7:0] for_m [16];
   int         ticks;
   bit         started = 0;
   logic       cur_v, pend_v, cur_k, pend_k;
   logic [7:0] cur_c, pend_c;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            bak_m[i] = dflt(4'(i));
            for_m[i] = dflt(4'(i));
         end
         ticks   = 0;
         cur_v   = 0; cur_c  = 8'h00; cur_k  = 1;
         pend_v  = 0; pend_c = 8'h00; pend_k = 1;
         started = 1;
      end else if (started) begin
         logic supp;
         logic [7:0] col;
         cur_v = pend_v; cur_c = pend_c; cur_k = pend_k;
`ifdef TXT_PALETTE_BLINK_EN
         supp = blink_attr && (((ticks / BF) % 2) == 1);
`else
         supp = 1'b0;
`endif
         if (blank)                col = 8'h00;
         else if (for_en && !supp) col = for_m[col_for];
         else                      col = bak_m[col_bak];
         pend_v = pix_valid; pend_c = col; pend_k = pix_valid;
         if (pal_we) begin
            if (pal_sel) for_m[pal_addr] = pal_data;
            else         bak_m[pal_addr] = pal_data;
         end
         if (frame_tick) ticks++;
      end
   end

   // One compare process, every cycle, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         checks++;
         if (rgb_valid !== cur_v) begin
            errors++;
            $display("FAIL model_valid t=%0t got=%b exp=%b", $time, rgb_valid, cur_v);
         end
         if (cur_k) begin
            checks++;
            if (rgb !== cur_c) begin
               errors++;
               $display("FAIL model_rgb t=%0t got=%h exp=%h", $time, rgb, cur_c);
            end
         end
      end
   end

   // rgb_valid cycle counter for the streaming test.
   bit cnt_en = 0;
   int vcnt   = 0;
   always @(negedge clk) if (cnt_en && rgb_valid === 1'b1) vcnt++;

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pix_valid = 0; for_en = 0; blank = 0; blink_attr = 0;
      frame_tick = 0; pal_we = 0;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Present one pixel, let it reach the output, return rgb/rgb_valid.
   task automatic run_pix(input logic fe, input logic [3:0] cf, input logic [3:0] cb,
                          input logic ba, input logic bl,
                          output logic [7:0] c, output logic v);
      pix_valid = 1; for_en = fe; col_for = cf; col_bak = cb;
      blink_attr = ba; blank = bl;
      step();
      idle();
      step();
      c = rgb; v = rgb_valid;
   endtask

   task automatic tick();
      frame_tick = 1; step();
      frame_tick = 0; step();
   endtask

   logic [7:0] c;
   logic       v;

   initial begin
      rst = 1; idle(); col_for = 0; col_bak = 0; pal_sel = 0; pal_addr = 0; pal_data = 0;
      step();
      chk("reset_rgb", rgb, 8'h00);
      chk("reset_valid", {7'd0, rgb_valid}, 8'h00);
      step();
      rst = 0;
      step();

      // Default palette entry 0xA -> 8'b1001_1110.
      run_pix(0, 4'h0, 4'hA, 0, 0, c, v);
      chk("dflt_bak_A", c, 8'h9E);
      chk("dflt_bak_A_valid", {7'd0, v}, 8'h01);

      // Write then read next cycle.
      pal_we = 1; pal_sel = 1; pal_addr = 4'd3; pal_data = 8'hE0;
      step();
      idle();
      run_pix(1, 4'd3, 4'd0, 0, 0, c, v);
      chk("wr_then_rd", c, 8'hE0);

      // Same-cycle write/read of bak_pal[3] returns old value, then the new.
      pal_we = 1; pal_sel = 0; pal_addr = 4'd3; pal_data = 8'h55;
      pix_valid = 1; for_en = 0; col_bak = 4'd3;
      step();
      pal_we = 0;
      step();
      chk("collision_old", rgb, 8'h0D);
      idle();
      step();
      chk("collision_new", rgb, 8'h55);

      // Blank forces black.
      run_pix(1, 4'd3, 4'hF, 0, 1, c, v);
      chk("blank", c, 8'h00);
      chk("blank_valid", {7'd0, v}, 8'h01);

      // 100 back-to-back pixels.
      step();
      vcnt = 0; cnt_en = 1;
      for (int i = 0; i < 100; i++) begin
         pix_valid = 1; for_en = i[0]; col_for = 4'(i + 5); col_bak = 4'(i);
         blank = (i % 17) == 0;
         step();
      end
      idle();
      repeat (4) step();
      cnt_en = 0;
      chk("stream_count", 8'(vcnt), 8'd100);

      // Blink: fg idx 5 = 8'h61, bg idx 2 = 8'h0C.
      run_pix(1, 4'd5, 4'd2, 1, 0, c, v);
      chk("blink_ph0", c, 8'h61);
      tick(); tick(); step();
      run_pix(1, 4'd5, 4'd2, 1, 0, c, v);
`ifdef TXT_PALETTE_BLINK_EN
      chk("blink_ph1", c, 8'h0C);
`else
      chk("blink_ph1", c, 8'h61);
`endif
      run_pix(1, 4'd5, 4'd2, 0, 0, c, v);
      chk("blink_noattr", c, 8'h61);
      tick(); tick(); step();
      run_pix(1, 4'd5, 4'd2, 1, 0, c, v);
      chk("blink_ph0_again", c, 8'h61);

      // Mid-stream reset, with a palette write that must be ignored.
      for (int i = 0; i < 3; i++) begin
         pix_valid = 1; for_en = 1; col_for = 4'd3; col_bak = 4'(i);
         step();
      end
      rst = 1; pal_we = 1; pal_sel = 1; pal_addr = 4'd7; pal_data = 8'hFF;
      step();
      chk("midrst_rgb", rgb, 8'h00);
      chk("midrst_valid", {7'd0, rgb_valid}, 8'h00);
      rst = 0; idle();
      step(); step();
      chk("post_rst_valid", {7'd0, rgb_valid}, 8'h00);

      run_pix(1, 4'd3, 4'd0, 0, 0, c, v);
      chk("readback_for3", c, 8'h0D);
      run_pix(0, 4'd0, 4'd3, 0, 0, c, v);
      chk("readback_bak3", c, 8'h0D);
      run_pix(1, 4'd7, 4'd0, 0, 0, c, v);
      chk("we_in_rst_ignored", c, 8'h6D);

      step(); step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
